// File: rtl/axil_req_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
// Modports give the master and slave views of the five channels.
interface axil_req_master_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/axil_req_master.sv
// Turns a simple valid/ready request port into single AXI4-Lite read or write
// transactions, returning a one-cycle response pulse; a watchdog aborts hung slaves.
module axil_req_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    axil_req_master_if.master     axil
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

    localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ~(ADDR_WIDTH'(3));

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  timeout_hit;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        // Holding off for the response cycle keeps a held req_valid from re-issuing early.
        req_ready    = (state_q == IDLE) && !rsp_valid_q;
        axil.awvalid = (state_q == WRITE) && !aw_done_q;
        axil.wvalid  = (state_q == WRITE) && !w_done_q;
        axil.bready  = (state_q == WRESP);
        axil.arvalid = (state_q == READ);
        axil.rready  = (state_q == RRESP);
        timeout_hit  = (count_q == TIMEOUT_LAST);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d    = req_addr & ALIGN_MASK;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (axil.awvalid && axil.awready) aw_done_d = 1'b1;
                if (axil.wvalid && axil.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            WRESP: begin
                if (axil.bvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (axil.bresp != 2'b00);
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            READ: begin
                if (axil.arready) begin
                    state_d = RRESP;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            RRESP: begin
                if (axil.rvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = axil.rdata;
                    rsp_err_d   = (axil.rresp != 2'b00);
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            count_d = '0;
        end else if (state_q != IDLE) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    assign axil.awaddr = addr_q;
    assign axil.araddr = addr_q;
    assign axil.awprot = 3'b000;
    assign axil.arprot = 3'b000;
    assign axil.wdata  = wdata_q;
    assign axil.wstrb  = wstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: doc/axil_req_master.md
AXIL_REQ_MASTER -- requirements
Module: axil_req_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, AXI4-Lite byte-address width (aligned words, bits [1:0] driven 0).
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for any slave handshake; range 1..65535.
REQ-003 aclk  in  1  single clock, all logic rising-edge.
REQ-004 areset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-007 req_we  in  1  1=write, 0=read.
REQ-008 req_addr  in  ADDR_WIDTH  byte address.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_wstrb  in  4  byte strobes.
REQ-011 rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-012 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-013 rsp_err  out  1  SLVERR/DECERR or timeout, valid with rsp_valid.
REQ-014 AXI4-Lite master ports: awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3], wvalid/wready/wdata[32]/wstrb[4], bvalid/bready/bresp[2], arvalid/arready/araddr[ADDR_WIDTH]/arprot[3], rvalid/rready/rdata[32]/rresp[2]; directions per master role.

Function
REQ-015 FSM states: IDLE, WRITE (AW and/or W pending), WRESP, READ (AR pending), RRESP.
REQ-016 req_ready SHALL be 1 only in IDLE; accepted request fields captured into registers in the accept cycle.
REQ-017 Write accept (cycle N): IDLE->WRITE; awvalid and wvalid both high from cycle N+1.
REQ-018 awvalid SHALL drop in the cycle after awready seen; wvalid likewise independently; address/data stable while valid.
REQ-019 When both AW and W handshakes complete (same or different cycles): WRITE->WRESP, bready=1.
REQ-020 On bvalid in WRESP: rsp_valid=1 next cycle, rsp_err=(bresp!=00), rsp_rdata=0, ->IDLE.
REQ-021 Read accept (cycle N): IDLE->READ; arvalid high from N+1 until arready seen, then ->RRESP, rready=1.
REQ-022 On rvalid in RRESP: rsp_valid=1 next cycle, rsp_rdata=rdata, rsp_err=(rresp!=00), ->IDLE.
REQ-023 bready and rready SHALL be 0 outside WRESP/RRESP respectively.
REQ-024 awprot=arprot=3'b000 constant.
REQ-025 16-bit timeout counter SHALL clear on each state entry and increment every non-IDLE cycle; reaching TIMEOUT SHALL force all valid/ready outputs low, rsp_valid=1, rsp_err=1, rsp_rdata=0, ->IDLE.
REQ-026 Handshake completing in the same cycle the counter reaches TIMEOUT SHALL take priority over timeout.
REQ-027 A new request SHALL be accepted no earlier than the cycle after rsp_valid.
REQ-028 req_valid while req_ready=0 SHALL be ignored; requester holds it.

Reset
REQ-029 areset_n low SHALL immediately force state IDLE, req_ready=1 after release, all AXI valid/ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, awaddr/araddr/wdata/wstrb=0, counter=0.
REQ-030 Reset mid-transaction SHALL abandon it with no rsp_valid pulse.

Verification
REQ-031 Write addr 0x4, data 0xDEADBEEF, wstrb 0xF, slave ready same cycle, bresp 00 -> one AW and one W handshake with those values, rsp_valid pulse, rsp_err=0.
REQ-032 Write with awready delayed 3 cycles after wready -> wvalid drops after 1 cycle, awvalid holds 4 cycles, single rsp_valid, rsp_err=0.
REQ-033 Read addr 0x0, slave returns rdata 0x12345678 rresp 00 -> rsp_rdata=0x12345678, rsp_err=0; read with rresp 10 -> rsp_err=1.
REQ-034 TIMEOUT=8, slave never asserts bvalid -> rsp_valid with rsp_err=1 exactly 8 cycles after WRESP entry, bready low afterwards, req_ready=1 next cycle.
REQ-035 areset_n pulsed low while arvalid=1 -> arvalid=0 immediately, no rsp_valid, next read completes normally.
REQ-036 Back-to-back write then read to the two-register AXI4-Lite slave (addr 0x0, 0x4) -> read returns the written value, req_valid held throughout causes no duplicate transaction.
